// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with prescaler, synchronous clear/load,
// wrap or saturate at the limits, and wrap/overflow/load-error flags.
module bcd_counter_multi #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  input  logic                      up_dn,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic                      wrap,
  output logic                      ovf,
  output logic                      load_err
);

  localparam int unsigned W  = 4 * NUM_DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);

  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap_q, wrap_d;
  logic          ovf_q, ovf_d;
  logic          load_err_q, load_err_d;

  logic          step;
  logic [W-1:0]  stepped;
  logic          at_limit;
  logic [W-1:0]  clamped;
  logic          any_clamped;

  // Prescaler: advances only while enabled, emits a step on its last phase.
  always_comb begin
    step    = en && (presc_q == PrescMax);
    presc_d = presc_q;
    if (en) begin
      presc_d = step ? '0 : presc_q + PW'(1);
    end
  end

  // Ripple the +1/-1 through the digits; a carry/borrow out of the MSD means the limit was hit.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    stepped = count_q;
    carry   = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (dig >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = dig + 4'd1;
            carry             = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = dig - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
    at_limit = carry;
  end

  // Clamp each loaded digit to 9 and note whether any needed clamping.
  always_comb begin
    clamped     = load_val;
    any_clamped = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        clamped[4*i +: 4] = 4'd9;
        any_clamped       = 1'b1;
      end
    end
  end

  // Next-state selection: clear beats load beats step.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    ovf_d      = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d    = clamped;
      load_err_d = any_clamped;
    end else if (step) begin
      wrap_d  = at_limit;
      ovf_d   = ovf_q | at_limit;
      count_d = (at_limit && SATURATE) ? count_q : stepped;
    end
  end

  // State registers; clear and load also restart the prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      presc_q    <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      presc_q    <= (clr || load) ? '0 : presc_d;
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench for bcd_counter_multi across four parameter sets.
module tb_bcd_counter_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: N=2 P=1 wrap; s: N=2 saturate; p: N=2 P=3; w: N=4
  logic       a_en = 0, a_clr = 0, a_load = 0, a_up = 1;
  logic [7:0] a_lv = '0, a_cnt;
  logic       a_wrap, a_ovf, a_lerr;
  logic       s_en = 0, s_clr = 0, s_load = 0, s_up = 1;
  logic [7:0] s_lv = '0, s_cnt;
  logic       s_wrap, s_ovf, s_lerr;
  logic       p_en = 0, p_clr = 0, p_load = 0, p_up = 1;
  logic [7:0] p_lv = '0, p_cnt;
  logic       p_wrap, p_ovf, p_lerr;
  logic        w_en = 0, w_clr = 0, w_load = 0, w_up = 1;
  logic [15:0] w_lv = '0, w_cnt;
  logic        w_wrap, w_ovf, w_lerr;

  bcd_counter_multi #(.NUM_DIGITS(2), .PRESCALE(1), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .up_dn(a_up), .count(a_cnt), .wrap(a_wrap), .ovf(a_ovf), .load_err(a_lerr));
  bcd_counter_multi #(.NUM_DIGITS(2), .PRESCALE(1), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .clr(s_clr), .load(s_load), .load_val(s_lv),
    .up_dn(s_up), .count(s_cnt), .wrap(s_wrap), .ovf(s_ovf), .load_err(s_lerr));
  bcd_counter_multi #(.NUM_DIGITS(2), .PRESCALE(3), .SATURATE(1'b0)) dut_p (
    .clk(clk), .rst(rst), .en(p_en), .clr(p_clr), .load(p_load), .load_val(p_lv),
    .up_dn(p_up), .count(p_cnt), .wrap(p_wrap), .ovf(p_ovf), .load_err(p_lerr));
  bcd_counter_multi #(.NUM_DIGITS(4), .PRESCALE(1), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(w_en), .clr(w_clr), .load(w_load), .load_val(w_lv),
    .up_dn(w_up), .count(w_cnt), .wrap(w_wrap), .ovf(w_ovf), .load_err(w_lerr));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;
    #3;
    chk("rst_count", 16'(a_cnt), 16'h00);
    chk("rst_wrap", 16'(a_wrap), 16'h0);
    chk("rst_ovf", 16'(a_ovf), 16'h0);
    chk("rst_lerr", 16'(a_lerr), 16'h0);
    #9 rst = 1'b1;

    // T1: count up from reset with decimal carry, then wrap 99 -> 00
    a_en = 1'b1;
    a_up = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      tick();
      e = 8'((i / 10) << 4) | 8'(i % 10);
      chk("t1_up", 16'(a_cnt), 16'(e));
      if (i == 10) chk("t1_ten", 16'(a_cnt), 16'h10);
    end
    chk("t1_nowrap", 16'(a_wrap), 16'h0);
    tick();
    chk("t1_wrapcnt", 16'(a_cnt), 16'h00);
    chk("t1_wrap", 16'(a_wrap), 16'h1);
    chk("t1_ovf", 16'(a_ovf), 16'h1);
    tick();
    chk("t1_after", 16'(a_cnt), 16'h01);
    chk("t1_wrapoff", 16'(a_wrap), 16'h0);
    chk("t1_ovfstick", 16'(a_ovf), 16'h1);

    // T2: load 00, count down through the lower limit, then clear
    a_load = 1'b1;
    a_lv   = 8'h00;
    a_up   = 1'b0;
    tick();
    a_load = 1'b0;
    chk("t2_load", 16'(a_cnt), 16'h00);
    chk("t2_ovfkeep", 16'(a_ovf), 16'h1);
    chk("t2_nowrap", 16'(a_wrap), 16'h0);
    tick();
    chk("t2_under", 16'(a_cnt), 16'h99);
    chk("t2_wrap", 16'(a_wrap), 16'h1);
    tick();
    chk("t2_98", 16'(a_cnt), 16'h98);
    chk("t2_wrapoff", 16'(a_wrap), 16'h0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_en  = 1'b0;
    chk("t2_clr", 16'(a_cnt), 16'h00);
    chk("t2_clrovf", 16'(a_ovf), 16'h0);

    // T5: clamped load, then clear overriding load
    a_load = 1'b1;
    a_lv   = 8'h4A;
    tick();
    a_load = 1'b0;
    chk("t5_clamp", 16'(a_cnt), 16'h49);
    chk("t5_lerr", 16'(a_lerr), 16'h1);
    tick();
    chk("t5_lerroff", 16'(a_lerr), 16'h0);
    chk("t5_hold", 16'(a_cnt), 16'h49);
    a_load = 1'b1;
    a_lv   = 8'hFC;
    tick();
    chk("t5_both", 16'(a_cnt), 16'h99);
    chk("t5_lerr2", 16'(a_lerr), 16'h1);
    a_lv  = 8'h4A;
    a_clr = 1'b1;
    tick();
    a_clr  = 1'b0;
    a_load = 1'b0;
    chk("t5_clrwins", 16'(a_cnt), 16'h00);
    chk("t5_clrlerr", 16'(a_lerr), 16'h0);
    a_lv  = 8'h37;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    chk("t5_okload", 16'(a_cnt), 16'h37);
    chk("t5_oklerr", 16'(a_lerr), 16'h0);

    // T3: saturating counter holds at 99 and pulses wrap each step
    s_load = 1'b1;
    s_lv   = 8'h99;
    s_en   = 1'b1;
    s_up   = 1'b1;
    tick();
    s_load = 1'b0;
    chk("t3_load", 16'(s_cnt), 16'h99);
    tick();
    chk("t3_hold1", 16'(s_cnt), 16'h99);
    chk("t3_wrap1", 16'(s_wrap), 16'h1);
    chk("t3_ovf", 16'(s_ovf), 16'h1);
    tick();
    chk("t3_hold2", 16'(s_cnt), 16'h99);
    chk("t3_wrap2", 16'(s_wrap), 16'h1);
    s_up = 1'b0;
    tick();
    chk("t3_down", 16'(s_cnt), 16'h98);
    chk("t3_wrapoff", 16'(s_wrap), 16'h0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    tick();
    chk("t3_satlow", 16'(s_cnt), 16'h00);
    chk("t3_satwrap", 16'(s_wrap), 16'h1);
    s_en = 1'b0;

    // T4: prescale by 3, with an enable gap that must preserve the phase
    p_en = 1'b1;
    tick();
    tick();
    chk("t4_wait", 16'(p_cnt), 16'h00);
    tick();
    chk("t4_step1", 16'(p_cnt), 16'h01);
    tick();
    p_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_gap", 16'(p_cnt), 16'h01);
    p_en = 1'b1;
    tick();
    chk("t4_phase", 16'(p_cnt), 16'h01);
    tick();
    chk("t4_step2", 16'(p_cnt), 16'h02);
    p_en = 1'b0;

    // T6: four digits, ripple across every digit, async reset mid-count
    w_load = 1'b1;
    w_lv   = 16'h0999;
    w_up   = 1'b1;
    w_en   = 1'b1;
    tick();
    w_load = 1'b0;
    tick();
    chk("t6_ripple", w_cnt, 16'h1000);
    w_up = 1'b0;
    tick();
    chk("t6_borrow", w_cnt, 16'h0999);
    w_load = 1'b1;
    w_lv   = 16'h9999;
    w_up   = 1'b1;
    tick();
    w_load = 1'b0;
    tick();
    chk("t6_wrap4", w_cnt, 16'h0000);
    chk("t6_wrapf", 16'(w_wrap), 16'h1);
    w_load = 1'b1;
    w_lv   = 16'h0123;
    tick();
    w_load = 1'b0;
    chk("t6_load", w_cnt, 16'h0123);
    tick();
    chk("t6_count", w_cnt, 16'h0124);
    #2 rst = 1'b0;
    #1;
    chk("t6_rstcnt", w_cnt, 16'h0000);
    chk("t6_rstovf", 16'(w_ovf), 16'h0);
    chk("t6_rstwrap", 16'(w_wrap), 16'h0);
    chk("t6_rstlerr", 16'(w_lerr), 16'h0);
    chk("t6_rsta", 16'(a_cnt), 16'h00);
    #2 rst = 1'b1;
    tick();
    chk("t6_resume", w_cnt, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
